// File: rtl/correlator_bank_if.sv
// rtl/correlator_bank_if.sv - sample/code stream and score/detect bundle for correlator_bank
//
// Purpose: groups the per-sample inputs and the per-window results of the
//          multi-lag correlator so they travel as one port.
// Signals:
//   sample_en  qualifies sig/code as a new sample this cycle
//   sig        received hard bit
//   code       local PN code bit
//   threshold  detect threshold, captured when a peak scan starts
//   values     per-lag scores, lag k at [k*OUT_W +: OUT_W]
//   peak_lag   index of the max score (lowest index on tie)
//   peak_value max score of the last completed scan
//   valid      1-cycle pulse when peak_lag/peak_value/detect update
//   detect     peak_value >= threshold, held until the next valid
// Modports: master drives the inputs (sample source), slave is the correlator.
interface correlator_bank_if #(
  parameter int N_LAGS = 8,
  parameter int OUT_W  = 8
);
  localparam int LAG_W = $clog2(N_LAGS);

  logic                    sample_en;
  logic                    sig;
  logic                    code;
  logic [OUT_W-1:0]        threshold;
  logic [N_LAGS*OUT_W-1:0] values;
  logic [LAG_W-1:0]        peak_lag;
  logic [OUT_W-1:0]        peak_value;
  logic                    valid;
  logic                    detect;

  modport master (
    output sample_en, sig, code, threshold,
    input  values, peak_lag, peak_value, valid, detect
  );

  modport slave (
    input  sample_en, sig, code, threshold,
    output values, peak_lag, peak_value, valid, detect
  );
endinterface

// File: rtl/correlator_bank.sv
// rtl/correlator_bank.sv - multi-lag 1-bit correlator with windowed scores and peak detect
//
// Purpose: compares the hard-sliced input against N_LAGS delayed copies of the
//          local PN code, integrates matches over 2**LOG2_INT samples, publishes
//          scaled per-lag scores at each window end and scans them for the peak.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active-low, highest priority
//   bus    correlator_bank_if.slave: sample_en/sig/code/threshold in,
//          values/peak_lag/peak_value/valid/detect out
module correlator_bank #(
  parameter int N_LAGS   = 8,
  parameter int LOG2_INT = 10,
  parameter int OUT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  correlator_bank_if.slave  bus
);
  localparam int LAG_W = $clog2(N_LAGS);
  localparam int ACC_W = LOG2_INT + 1;   // holds 2**LOG2_INT without wrapping
  localparam int SHIFT = LOG2_INT - OUT_W;
  localparam logic [LOG2_INT-1:0] CNT_MAX  = '1;
  localparam logic [LAG_W-1:0]    LAST_LAG = LAG_W'(N_LAGS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, next_state;

  logic                  sig_q, code_q, en_q;
  logic [N_LAGS-2:0]     dl_q;           // dl_q[j] = code delayed j+1 samples
  logic [N_LAGS-1:0]     lag_bits;
  logic [N_LAGS-1:0]     match;
  logic [ACC_W-1:0]      acc [N_LAGS];
  logic [ACC_W-1:0]      full [N_LAGS];
  logic [ACC_W-1:0]      scaled [N_LAGS];
  logic [OUT_W-1:0]      values_next [N_LAGS];
  logic [OUT_W-1:0]      values_q [N_LAGS];
  logic [LOG2_INT-1:0]   cnt;
  logic                  win_end;

  logic [LAG_W-1:0]      scan_idx;
  logic [LAG_W-1:0]      best_idx;
  logic [OUT_W-1:0]      best_val;
  logic [OUT_W-1:0]      thr_q;
  logic [OUT_W-1:0]      cur_val;
  logic                  publish;

  logic [LAG_W-1:0]      peak_lag_q;
  logic [OUT_W-1:0]      peak_value_q;
  logic                  valid_q;
  logic                  detect_q;

  // Lag 0 uses the freshly registered code bit directly.
  assign lag_bits = {dl_q, code_q};
  assign match    = ~(lag_bits ^ {N_LAGS{sig_q}});
  assign win_end  = en_q && (cnt == CNT_MAX);
  assign cur_val  = values_q[scan_idx];

  // The closing sample is folded in here so the published score covers the
  // whole window; a perfect match reaches 2**LOG2_INT and must saturate.
  always_comb begin
    for (int k = 0; k < N_LAGS; k++) begin
      full[k]        = acc[k] + ACC_W'(match[k]);
      scaled[k]      = full[k] >> SHIFT;
      values_next[k] = (|scaled[k][ACC_W-1:OUT_W]) ? '1 : scaled[k][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A window end always (re)starts the scan, which silently drops any scan
  // still in flight on the old values.
  always_comb begin
    next_state = state;
    publish    = 1'b0;
    if (win_end) begin
      next_state = SCAN;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        SCAN: if (scan_idx == LAST_LAG) next_state = DONE;
        DONE: begin
          next_state = IDLE;
          publish    = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q        <= 1'b0;
      code_q       <= 1'b0;
      en_q         <= 1'b0;
      dl_q         <= '0;
      cnt          <= '0;
      for (int k = 0; k < N_LAGS; k++) begin
        acc[k]      <= '0;
        values_q[k] <= '0;
      end
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      thr_q        <= '0;
      peak_lag_q   <= '0;
      peak_value_q <= '0;
      valid_q      <= 1'b0;
      detect_q     <= 1'b0;
    end else begin
      sig_q  <= bus.sig;
      code_q <= bus.code;
      en_q   <= bus.sample_en;

      if (en_q) begin
        dl_q[0] <= code_q;
        for (int j = 1; j < N_LAGS - 1; j++) dl_q[j] <= dl_q[j-1];
        cnt <= cnt + LOG2_INT'(1);
        for (int k = 0; k < N_LAGS; k++) acc[k] <= win_end ? '0 : full[k];
        if (win_end) begin
          for (int k = 0; k < N_LAGS; k++) values_q[k] <= values_next[k];
        end
      end

      // Best starts at 0 with strict '>' so ties keep the lowest lag.
      if (win_end) begin
        scan_idx <= '0;
        best_idx <= '0;
        best_val <= '0;
        thr_q    <= bus.threshold;
      end else if (state == SCAN) begin
        if (cur_val > best_val) begin
          best_val <= cur_val;
          best_idx <= scan_idx;
        end
        scan_idx <= scan_idx + LAG_W'(1);
      end

      valid_q <= publish;
      if (publish) begin
        peak_lag_q   <= best_idx;
        peak_value_q <= best_val;
        detect_q     <= (best_val >= thr_q);
      end
    end
  end

  for (genvar k = 0; k < N_LAGS; k++) begin : g_pack
    assign bus.values[k*OUT_W +: OUT_W] = values_q[k];
  end

  assign bus.peak_lag   = peak_lag_q;
  assign bus.peak_value = peak_value_q;
  assign bus.valid      = valid_q;
  assign bus.detect     = detect_q;
endmodule

// File: tb/tb_correlator_bank.sv
// tb/tb_correlator_bank.sv - table-driven self-checking bench for correlator_bank
module tb_correlator_bank;
  localparam int N_LAGS   = 8;
  localparam int LOG2_INT = 10;
  localparam int OUT_W    = 8;
  localparam int WIN      = 1 << LOG2_INT;
  localparam int MAXV     = (1 << OUT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  correlator_bank_if #(.N_LAGS(N_LAGS), .OUT_W(OUT_W)) bus ();

  correlator_bank #(.N_LAGS(N_LAGS), .LOG2_INT(LOG2_INT), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // mode: 0 sig=code, 1 sig=code delayed 3, 2 sig=~code, 3 sig=code=1
  typedef struct {
    int mode;
    int en_div;
    int thr;
    int rst_at;
    int chk_lag;
    int chk_val;
    int exp_peak;   // -1: any non-zero lag
    int exp_det;
  } vec_t;

  vec_t vecs [8];
  int errors = 0;
  int checks = 0;
  logic [14:0] pn;

  function automatic logic code_at(int mode, int n);
    if (n < 0) return 1'b0;
    if (mode == 3) return 1'b1;
    return pn[n % 15];
  endfunction

  function automatic logic sig_at(int mode, int n);
    case (mode)
      1:       return code_at(mode, n - 3);
      2:       return ~code_at(mode, n);
      default: return code_at(mode, n);
    endcase
  endfunction

  // Score of lag k over window w counted directly from the sample streams;
  // code before the first post-reset sample reads as 0.
  function automatic int ref_val(int mode, int w, int k);
    int c = 0;
    for (int n = w * WIN; n < (w + 1) * WIN; n++)
      if (sig_at(mode, n) == code_at(mode, n - k)) c++;
    c = c >> (LOG2_INT - OUT_W);
    return (c > MAXV) ? MAXV : c;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(int vi);
    vec_t v;
    int c, n, vcount, s_last, first_valid, change_c, rel_c, target, budget, w;
    int best_k, best_v, r;
    bit did_rst, pending_rst, prev_valid, done;
    logic [N_LAGS*OUT_W-1:0] prev_vals;
    v = vecs[vi];

    rst_n = 1'b0;
    bus.sample_en = 1'b0;
    bus.sig = 1'b0;
    bus.code = 1'b0;
    bus.threshold = OUT_W'(v.thr);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("v%0d reset_outputs_zero", vi),
          int'(bus.values == '0 && bus.peak_lag == '0 && bus.peak_value == '0
               && !bus.valid && !bus.detect), 1);

    c = 0; n = 0; vcount = 0; s_last = -1; first_valid = -1; change_c = -1;
    rel_c = 0; target = 2; did_rst = 0; pending_rst = 0; prev_valid = 0; done = 0;
    prev_vals = '0;
    budget = 3 * WIN * v.en_div + 200;

    while (!done && c < budget) begin
      if (v.rst_at >= 0 && !did_rst && n == v.rst_at) begin
        rst_n = 1'b0;
        bus.sample_en = 1'b0;
        pending_rst = 1;
      end else begin
        rst_n = 1'b1;
        if ((c % v.en_div) == 0) begin
          bus.sample_en = 1'b1;
          bus.sig  = sig_at(v.mode, n);
          bus.code = code_at(v.mode, n);
          if ((n % WIN) == WIN - 1) s_last = c;
          n++;
        end else begin
          bus.sample_en = 1'b0;
          bus.sig  = 1'($urandom_range(0, 1));
          bus.code = 1'($urandom_range(0, 1));
        end
      end

      @(posedge clk);
      #1;
      c++;

      if (pending_rst) begin
        pending_rst = 0;
        did_rst = 1;
        check($sformatf("v%0d midrun_reset_outputs_zero", vi),
              int'(bus.values == '0 && bus.peak_lag == '0 && bus.peak_value == '0
                   && !bus.valid && !bus.detect), 1);
        n = 0; vcount = 0; target = 1; rel_c = c; prev_vals = '0; prev_valid = 0;
      end else begin
        if (bus.values != prev_vals) begin
          change_c = c;
          prev_vals = bus.values;
        end
        if (prev_valid) check($sformatf("v%0d valid_width", vi), int'(bus.valid), 0);
        prev_valid = bus.valid;
        if (bus.valid) begin
          vcount++;
          if (vcount == 1) begin
            check($sformatf("v%0d valid_latency", vi), c - s_last, 3 + N_LAGS);
            check($sformatf("v%0d values_latency", vi), change_c - s_last, 2);
            if (did_rst)
              check($sformatf("v%0d valid_after_release", vi), c - rel_c, WIN - 1 + 3 + N_LAGS);
            first_valid = c;
          end
          if (vcount == 2)
            check($sformatf("v%0d valid_interval", vi), c - first_valid, WIN * v.en_div);
          if (vcount == target) done = 1;
        end
      end
    end

    if (!done) begin
      check($sformatf("v%0d timeout_waiting_valid", vi), 0, 1);
    end else begin
      w = target - 1;
      best_k = 0; best_v = 0;
      for (int k = 0; k < N_LAGS; k++) begin
        r = ref_val(v.mode, w, k);
        check($sformatf("v%0d lag%0d_score", vi, k), int'(bus.values[k*OUT_W +: OUT_W]), r);
        if (r > best_v) begin best_v = r; best_k = k; end
      end
      check($sformatf("v%0d peak_lag_ref", vi), int'(bus.peak_lag), best_k);
      check($sformatf("v%0d peak_value_ref", vi), int'(bus.peak_value), best_v);
      check($sformatf("v%0d detect_ref", vi), int'(bus.detect), int'(best_v >= v.thr));
      check($sformatf("v%0d hand_lag%0d", vi, v.chk_lag),
            int'(bus.values[v.chk_lag*OUT_W +: OUT_W]), v.chk_val);
      if (v.exp_peak >= 0)
        check($sformatf("v%0d hand_peak_lag", vi), int'(bus.peak_lag), v.exp_peak);
      else
        check($sformatf("v%0d hand_peak_nonzero", vi), int'(bus.peak_lag != '0), 1);
      check($sformatf("v%0d hand_detect", vi), int'(bus.detect), v.exp_det);

      bus.sample_en = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d final_valid_width", vi), int'(bus.valid), 0);
      check($sformatf("v%0d results_held", vi),
            int'(bus.peak_lag == best_k[$clog2(N_LAGS)-1:0]), 1);
    end
  endtask

  initial begin
    pn = 15'b111101011001000;
    //         mode en  thr  rst   lag val  peak det
    vecs[0] = '{0,   1, 200,   -1, 0, 255,   0, 1};
    vecs[1] = '{1,   1, 200,   -1, 3, 255,   3, 1};
    vecs[2] = '{2,   1,   1,   -1, 0,   0,  -1, 1};
    vecs[3] = '{0,   4, 200,   -1, 0, 255,   0, 1};
    vecs[4] = '{0,   1, 200, 1524, 0, 255,   0, 1};
    vecs[5] = '{3,   1, 200,   -1, 7, 255,   0, 1};
    vecs[6] = '{1,   1, 255,   -1, 3, 255,   3, 1};
    vecs[7] = '{2,   1, 200,   -1, 0,   0,  -1, 0};

    for (int i = 0; i < 8; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
